// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e    : operation codes presented on md_op (6 and 7 are reserved)
//   md_state_e : sequencer states
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath for md_sched.
//   op       : operation code (md_op_e encoding)
//   a, b     : rs / rt operands
//   res_hi   : product[63:32] for MULT/MULTU, remainder for DIV/DIVU, else 0
//   res_lo   : product[31:0]  for MULT/MULTU, quotient  for DIV/DIVU, else 0
//   div_zero : DIV/DIVU with a zero divisor
module md_alu
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0]        prod_s, prod_u;
  logic               b_zero, div_ovf;
  logic [31:0]        bs_div, bu_div;
  logic signed [31:0] q_s, r_s;
  logic [31:0]        q_u, r_u;

  always_comb begin
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};

    b_zero  = (b == 32'd0);
    div_ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    // Zero divisors are replaced so the divider never sees them (results are discarded
    // anyway). The signed overflow case divides by 1, which yields exactly
    // quotient 0x80000000 / remainder 0.
    bs_div  = (b_zero || div_ovf) ? 32'd1 : b;
    bu_div  = b_zero ? 32'd1 : b;

    q_s     = $signed(a) / $signed(bs_div);
    r_s     = $signed(a) % $signed(bs_div);
    q_u     = a / bu_div;
    r_u     = a % bu_div;

    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (md_op_e'(op))
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_hi   = r_s;
        res_lo   = q_s;
        div_zero = b_zero;
      end
      MD_DIVU: begin
        res_hi   = r_u;
        res_lo   = q_u;
        div_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair (E stage).
//   clk, reset : clock, synchronous active-high reset
//   start      : operation valid, md_op selects the operation
//   A, B       : rs / rt operands
//   abort      : flush; cancels an in-flight operation or a same-cycle start
//   hl_sel     : hl_rd select, 1 = HI, 0 = LO
//   busy       : high for exactly MULT_LAT / DIV_LAT cycles after an accepted mult/div
//   hl_rd      : combinational read of the architectural HI or LO
//   HI, LO     : architectural HI / LO
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        abort,
  input  logic        hl_sel,
  output logic        busy,
  output logic [31:0] hl_rd,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  md_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic          pend_dz_q, busy_q;
  logic [31:0]   alu_hi, alu_lo;
  logic          alu_dz;

  md_alu u_alu (
    .op       (md_op),
    .a        (A),
    .b        (B),
    .res_hi   (alu_hi),
    .res_lo   (alu_lo),
    .div_zero (alu_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start && !abort) begin
            case (md_op_e'(md_op))
              MD_MULT, MD_MULTU: begin
                pend_hi_q <= alu_hi;
                pend_lo_q <= alu_lo;
                pend_dz_q <= 1'b0;
                cnt_q     <= CntW'(MULT_LAT);
                state_q   <= MD_BUSY;
                busy_q    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi_q <= alu_hi;
                pend_lo_q <= alu_lo;
                pend_dz_q <= alu_dz;
                cnt_q     <= CntW'(DIV_LAT);
                state_q   <= MD_BUSY;
                busy_q    <= 1'b1;
              end
              MD_MTHI: hi_q <= A;
              MD_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        MD_BUSY: begin
          if (abort) begin
            state_q   <= MD_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              // A zero divisor burns the full latency but leaves HI/LO untouched.
              if (!pend_dz_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
              end
              state_q <= MD_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  // Reads the architectural pair only; in-flight results are never forwarded.
  assign hl_rd = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
  import md_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort, hl_sel;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hl_rd, hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_sched #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .A      (a),
    .B      (b),
    .abort  (abort),
    .hl_sel (hl_sel),
    .busy   (busy),
    .hl_rd  (hl_rd),
    .HI     (hi),
    .LO     (lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // The hazard unit must never present start while an operation is in flight.
  always @(posedge clk) begin
    if (busy === 1'b1) check("no_start_while_busy", {31'd0, start}, 32'd0);
  end

  // Pulse start for one edge; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    md_op = op;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy high, bounded so a stuck busy still terminates.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] av,
                     input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo);
    int n;
    issue(op, av, bv);
    wait_idle(n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    hl_sel = 1'b0;
    md_op  = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_hl_rd", hl_rd, 32'd0);
    reset = 1'b0;

    run("mult",       MD_MULT,  32'hffff_ffff, 32'd2,         5,  32'hffff_ffff, 32'hffff_fffe);
    run("multu",      MD_MULTU, 32'hffff_ffff, 32'd2,         5,  32'h0000_0001, 32'hffff_fffe);
    run("mult_neg",   MD_MULT,  32'hffff_fffd, 32'd7,         5,  32'hffff_ffff, 32'hffff_ffeb);
    run("div",        MD_DIV,   32'hffff_fff9, 32'd2,         10, 32'hffff_ffff, 32'hffff_fffd);
    run("div_negdiv", MD_DIV,   32'd7,         32'hffff_fffe, 10, 32'h0000_0001, 32'hffff_fffd);
    run("div_ovf",    MD_DIV,   32'h8000_0000, 32'hffff_ffff, 10, 32'h0000_0000, 32'h8000_0000);
    run("divu",       MD_DIVU,  32'h8000_0000, 32'hffff_ffff, 10, 32'h8000_0000, 32'h0000_0000);
    run("divu_plain", MD_DIVU,  32'd100,       32'd7,         10, 32'd2,         32'd14);

    // MTHI then MTLO on back-to-back edges
    @(negedge clk);
    md_op = MD_MTHI;
    a     = 32'hdead_beef;
    start = 1'b1;
    @(negedge clk);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'hdead_beef);
    md_op  = MD_MTLO;
    a      = 32'h1234_5678;
    hl_sel = 1'b1;
    #1;
    check("hl_rd_hi", hl_rd, 32'hdead_beef);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi_kept", hi, 32'hdead_beef);
    hl_sel = 1'b0;
    #1;
    check("hl_rd_lo", hl_rd, 32'h1234_5678);

    // Zero divisor: full latency, HI/LO untouched
    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    run("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'h11, 32'h22);

    // Abort on the 4th busy cycle of a DIV
    issue(MD_MTHI, 32'd1, 32'd0);
    issue(MD_MTLO, 32'd2, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd1);
    check("abort_lo", lo, 32'd2);
    repeat (12) @(negedge clk);
    check("abort_hi_late", hi, 32'd1);
    check("abort_lo_late", lo, 32'd2);

    // start and abort together: ignored
    @(negedge clk);
    md_op = MD_MULT;
    a     = 32'd3;
    b     = 32'd3;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    md_op = MD_MTHI;
    a     = 32'h55;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    check("start_abort_hi", hi, 32'd1);
    check("start_abort_lo", lo, 32'd2);

    // Reset on the 3rd busy cycle of a MULT
    issue(MD_MULT, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    wait_idle(n);
    check("rst_mid_stays_idle", n, 0);
    run("mult_after_rst", MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
